// File: rtl/arb_scoreboard_if.sv
// Bundle of the request/grant bus and checker outputs seen by arb_scoreboard.
// master: the harness or arbiter side; slave: the scoreboard.
interface arb_scoreboard_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic [N-1:0]     req;
  logic [N-1:0]     dut_gnt;
  logic             chk_en;
  logic [N-1:0]     exp_gnt;
  logic             mismatch;
  logic             multi_err;
  logic [CNT_W-1:0] err_count;
  logic [N-1:0]     first_err_gnt;

  modport master (
    output req, dut_gnt, chk_en,
    input  exp_gnt, mismatch, multi_err, err_count, first_err_gnt
  );

  modport slave (
    input  req, dut_gnt, chk_en,
    output exp_gnt, mismatch, multi_err, err_count, first_err_gnt
  );
endinterface

// File: rtl/arb_scoreboard.sv
// arb_scoreboard: cycle-accurate reference model of an N-requester arbiter
// (fixed priority or round-robin) with per-cycle grant comparison,
// multi-grant detection, a saturating error counter and first-error capture.
//
// state   | meaning
// ST_IDLE | no holder; the next edge arbitrates among pending requests
// ST_HOLD | exp_gnt names the holder; it keeps the grant while its req stays high
module arb_scoreboard #(
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst,
  arb_scoreboard_if.slave bus
);

  localparam int               IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [N-1:0]     ONE_N    = N'(1);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     exp_gnt_q, exp_gnt_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic [N-1:0]     pick_fixed;
  logic [N-1:0]     pick_rr;
  logic [IDX_W-1:0] idx_rr;
  logic             rr_found;
  logic [IDX_W-1:0] scan;

  logic             gnt_differs;
  logic             gnt_multi;
  logic             mismatch_d;
  logic             multi_err_d;

  logic             mismatch_q;
  logic             multi_err_q;
  logic [CNT_W-1:0] err_count_q;
  logic [N-1:0]     first_err_q;
  logic             first_seen_q;

  // Fixed priority: lowest set index wins (scan downward so the lowest overwrites last).
  always_comb begin
    pick_fixed = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        pick_fixed    = '0;
        pick_fixed[i] = 1'b1;
      end
    end
  end

  // Round-robin: first set index scanning last+1, last+2, ... modulo N.
  always_comb begin
    pick_rr  = '0;
    idx_rr   = last_q;
    rr_found = 1'b0;
    scan     = '0;
    for (int k = 1; k <= N; k++) begin
      scan = IDX_W'((int'(last_q) + k) % N);
      if (!rr_found && bus.req[scan]) begin
        rr_found      = 1'b1;
        pick_rr[scan] = 1'b1;
        idx_rr        = scan;
      end
    end
  end

  // Model next state: a holder is never preempted, and its release always
  // leaves one idle cycle before the next grant.
  always_comb begin
    state_d   = state_q;
    exp_gnt_d = exp_gnt_q;
    last_d    = last_q;
    case (state_q)
      ST_HOLD: begin
        if ((exp_gnt_q & bus.req) == '0) begin
          state_d   = ST_IDLE;
          exp_gnt_d = '0;
        end
      end
      ST_IDLE: begin
        if (bus.req != '0) begin
          state_d = ST_HOLD;
          if (MODE == 1) begin
            exp_gnt_d = pick_rr;
            last_d    = idx_rr;
          end else begin
            exp_gnt_d = pick_fixed;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        exp_gnt_d = '0;
      end
    endcase
  end

  // Model state register; runs regardless of chk_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      exp_gnt_q <= '0;
      last_q    <= LAST_RST;
    end else begin
      state_q   <= state_d;
      exp_gnt_q <= exp_gnt_d;
      last_q    <= last_d;
    end
  end

  // Comparison is against the model's current output, so errors appear one edge later.
  assign gnt_differs = (bus.dut_gnt != exp_gnt_q);
  assign gnt_multi   = ((bus.dut_gnt & (bus.dut_gnt - ONE_N)) != '0);
  assign mismatch_d  = bus.chk_en & gnt_differs;
  assign multi_err_d = bus.chk_en & gnt_multi;

  // Error reporting: pulses, saturating counter and first-mismatch capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_q   <= 1'b0;
      multi_err_q  <= 1'b0;
      err_count_q  <= '0;
      first_err_q  <= '0;
      first_seen_q <= 1'b0;
    end else begin
      mismatch_q  <= mismatch_d;
      multi_err_q <= multi_err_d;
      if (mismatch_d && (err_count_q != CNT_MAX)) begin
        err_count_q <= err_count_q + 1'b1;
      end
      if (mismatch_d && !first_seen_q) begin
        first_err_q  <= bus.dut_gnt;
        first_seen_q <= 1'b1;
      end
    end
  end

  assign bus.exp_gnt       = exp_gnt_q;
  assign bus.mismatch      = mismatch_q;
  assign bus.multi_err     = multi_err_q;
  assign bus.err_count     = err_count_q;
  assign bus.first_err_gnt = first_err_q;

endmodule

// File: tb/tb_arb_scoreboard.sv
// Bench for arb_scoreboard: directed table (fixed priority), round-robin
// rotation, counter saturation with async reset, then random traffic against
// an index-based behavioural model for both policies.
module tb_arb_scoreboard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_scoreboard_if #(.N(4), .CNT_W(8)) if0 ();
  arb_scoreboard_if #(.N(4), .CNT_W(8)) if1 ();
  arb_scoreboard_if #(.N(4), .CNT_W(2)) if2 ();

  arb_scoreboard #(.N(4), .MODE(0), .CNT_W(8)) u_fix (.clk(clk), .rst(rst), .bus(if0.slave));
  arb_scoreboard #(.N(4), .MODE(1), .CNT_W(8)) u_rr  (.clk(clk), .rst(rst), .bus(if1.slave));
  arb_scoreboard #(.N(4), .MODE(0), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(if2.slave));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] dut;
    logic       chk;
    logic [3:0] exp;
    logic       mm;
    logic       me;
    logic [7:0] cnt;
    logic [3:0] first;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    if0.req = '0; if0.dut_gnt = '0; if0.chk_en = 1'b0;
    if1.req = '0; if1.dut_gnt = '0; if1.chk_en = 1'b0;
    if2.req = '0; if2.dut_gnt = '0; if2.chk_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
  endtask

  // Spec-level arbiter model: holder index (-1 = none) and last-holder index.
  function automatic void arb_next(input int mode, input logic [3:0] r,
                                   inout int h, inout int l);
    if (h >= 0) begin
      if (!r[h]) h = -1;
    end else if (r != 4'b0000) begin
      if (mode == 0) begin
        for (int i = 3; i >= 0; i--) if (r[i]) h = i;
      end else begin
        for (int k = 4; k >= 1; k--) if (r[(l + k) % 4]) h = (l + k) % 4;
        l = h;
      end
    end
  endfunction

  function automatic logic [3:0] onehot(input int h);
    return (h < 0) ? 4'b0000 : 4'(1 << h);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish by time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0] rr_seq [9];
    logic [3:0] prev;
    logic [7:0] sat_cnt [5];
    int         hold [2], last [2], cnt [2];
    logic [3:0] first [2];
    bit         seen [2];
    logic [3:0] r [2], d [2], cur;
    logic       c [2], em [2], ee [2];

    //            req      dut      chk   exp      mm    me    cnt    first
    tbl[0]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 8'd0, 4'b0000};
    tbl[1]  = '{4'b0111, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b0, 8'd0, 4'b0000};
    tbl[2]  = '{4'b0101, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd0, 4'b0000};
    tbl[3]  = '{4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 8'd0, 4'b0000};
    tbl[4]  = '{4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 8'd0, 4'b0000};
    tbl[5]  = '{4'b0010, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd0, 4'b0000};
    tbl[6]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 8'd0, 4'b0000};
    tbl[7]  = '{4'b0010, 4'b0100, 1'b1, 4'b0010, 1'b1, 1'b0, 8'd1, 4'b0100};
    tbl[8]  = '{4'b0010, 4'b1000, 1'b1, 4'b0010, 1'b1, 1'b0, 8'd2, 4'b0100};
    tbl[9]  = '{4'b0010, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b1, 8'd3, 4'b0100};
    tbl[10] = '{4'b0010, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, 8'd3, 4'b0100};
    tbl[11] = '{4'b0000, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd3, 4'b0100};
    tbl[12] = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 8'd3, 4'b0100};
    tbl[13] = '{4'b1001, 4'b1000, 1'b1, 4'b1000, 1'b0, 1'b0, 8'd3, 4'b0100};
    tbl[14] = '{4'b0001, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd3, 4'b0100};
    tbl[15] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 8'd3, 4'b0100};

    rr_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
               4'b0000, 4'b1000, 4'b0000, 4'b0001};
    sat_cnt = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};

    // Reset state
    do_reset();
    chk("rst exp_gnt",       32'(if0.exp_gnt), 32'd0);
    chk("rst mismatch",      32'(if0.mismatch), 32'd0);
    chk("rst multi_err",     32'(if0.multi_err), 32'd0);
    chk("rst err_count",     32'(if0.err_count), 32'd0);
    chk("rst first_err_gnt", 32'(if0.first_err_gnt), 32'd0);
    chk("rst rr exp_gnt",    32'(if1.exp_gnt), 32'd0);

    // Fixed-priority directed table
    for (int i = 0; i < 16; i++) begin
      if0.req = tbl[i].req; if0.dut_gnt = tbl[i].dut; if0.chk_en = tbl[i].chk;
      step();
      chk($sformatf("tbl%0d exp_gnt", i),   32'(if0.exp_gnt),       32'(tbl[i].exp));
      chk($sformatf("tbl%0d mismatch", i),  32'(if0.mismatch),      32'(tbl[i].mm));
      chk($sformatf("tbl%0d multi_err", i), 32'(if0.multi_err),     32'(tbl[i].me));
      chk($sformatf("tbl%0d err_count", i), 32'(if0.err_count),     32'(tbl[i].cnt));
      chk($sformatf("tbl%0d first_err", i), 32'(if0.first_err_gnt), 32'(tbl[i].first));
    end

    // Round-robin rotation: every holder releases after one cycle
    prev = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      if1.req = (prev == 4'b0000) ? 4'b1111 : ~prev;
      step();
      chk($sformatf("rr%0d exp_gnt", i), 32'(if1.exp_gnt), 32'(rr_seq[i]));
      prev = rr_seq[i];
    end
    if1.req = 4'b0000;

    // 2-bit counter saturation
    if2.chk_en = 1'b1; if2.req = 4'b0000; if2.dut_gnt = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("sat%0d mismatch", i),  32'(if2.mismatch),  32'd1);
      chk($sformatf("sat%0d err_count", i), 32'(if2.err_count), 32'(sat_cnt[i]));
    end
    chk("sat first_err", 32'(if2.first_err_gnt), 32'b0001);
    if2.req = 4'b0001; if2.dut_gnt = 4'b0010;
    step();
    chk("sat hold exp_gnt",   32'(if2.exp_gnt),   32'b0001);
    chk("sat hold mismatch",  32'(if2.mismatch),  32'd1);
    chk("sat hold err_count", 32'(if2.err_count), 32'd3);

    // Asynchronous reset mid-grant, observed before the next edge
    #3 rst = 1'b1;
    #1;
    chk("async exp_gnt",     32'(if2.exp_gnt),       32'd0);
    chk("async mismatch",    32'(if2.mismatch),      32'd0);
    chk("async err_count",   32'(if2.err_count),     32'd0);
    chk("async first_err",   32'(if2.first_err_gnt), 32'd0);
    chk("async fix exp_gnt", 32'(if0.exp_gnt),       32'd0);
    chk("async fix cnt",     32'(if0.err_count),     32'd0);
    #2 rst = 1'b0;
    if2.dut_gnt = 4'b0000; if2.chk_en = 1'b0;
    step();
    chk("post rst exp_gnt",  32'(if2.exp_gnt),  32'b0001);
    chk("post rst mismatch", 32'(if2.mismatch), 32'd0);

    // Random traffic vs behavioural model, both policies
    do_reset();
    for (int j = 0; j < 2; j++) begin
      hold[j] = -1; last[j] = 3; cnt[j] = 0; first[j] = 4'b0000; seen[j] = 1'b0;
    end
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < 2; j++) begin
        cur  = onehot(hold[j]);
        r[j] = 4'($urandom_range(0, 15));
        if (hold[j] >= 0 && $urandom_range(0, 3) != 0) r[j] = r[j] | cur;
        d[j] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : cur;
        c[j] = ($urandom_range(0, 4) != 0);
        em[j] = c[j] && (d[j] != cur);
        ee[j] = c[j] && ($countones(d[j]) > 1);
        if (em[j]) begin
          if (cnt[j] < 255) cnt[j]++;
          if (!seen[j]) begin seen[j] = 1'b1; first[j] = d[j]; end
        end
        arb_next(j, r[j], hold[j], last[j]);
      end
      if0.req = r[0]; if0.dut_gnt = d[0]; if0.chk_en = c[0];
      if1.req = r[1]; if1.dut_gnt = d[1]; if1.chk_en = c[1];
      step();
      chk($sformatf("rnd%0d fix exp_gnt", n), 32'(if0.exp_gnt),       32'(onehot(hold[0])));
      chk($sformatf("rnd%0d fix mm", n),      32'(if0.mismatch),      32'(em[0]));
      chk($sformatf("rnd%0d fix me", n),      32'(if0.multi_err),     32'(ee[0]));
      chk($sformatf("rnd%0d fix cnt", n),     32'(if0.err_count),     32'(cnt[0]));
      chk($sformatf("rnd%0d fix first", n),   32'(if0.first_err_gnt), 32'(first[0]));
      chk($sformatf("rnd%0d rr exp_gnt", n),  32'(if1.exp_gnt),       32'(onehot(hold[1])));
      chk($sformatf("rnd%0d rr mm", n),       32'(if1.mismatch),      32'(em[1]));
      chk($sformatf("rnd%0d rr me", n),       32'(if1.multi_err),     32'(ee[1]));
      chk($sformatf("rnd%0d rr cnt", n),      32'(if1.err_count),     32'(cnt[1]));
      chk($sformatf("rnd%0d rr first", n),    32'(if1.first_err_gnt), 32'(first[1]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
